// File: rtl/input_port_cluster_pkg.sv
// Shared definitions for the input port cluster: packet field positions,
// credit arbiter state encoding and the pending-credit counter width.
package input_port_cluster_pkg;

  // Pending credits per port; depth / credit batch size must fit in this width.
  localparam int PENDING_BITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Packet layout, MSB first: valid | leaf | port | ... | payload
  function automatic int valid_bit(input int packet_bits);
    return packet_bits - 1;
  endfunction

  function automatic int leaf_lsb(input int packet_bits, input int leaf_bits);
    return packet_bits - 1 - leaf_bits;
  endfunction

  function automatic int port_lsb(input int packet_bits, input int leaf_bits,
                                  input int port_bits);
    return packet_bits - 1 - leaf_bits - port_bits;
  endfunction

  function automatic int payload_msb(input int payload_bits);
    return payload_bits - 1;
  endfunction

endpackage

// File: rtl/input_port_fifo.sv
// Per-port synchronous FIFO with a first-word-fall-through head. A write
// on a full FIFO is accepted when a pop happens in the same cycle. The
// head reads as zero while the FIFO is empty.
module input_port_fifo #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 7
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [DATA_BITS-1:0] o_head,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_do_wr;
  logic                 w_do_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);
  assign w_do_rd = i_rd_en & ~o_empty;
  assign w_do_wr = i_wr_en & (~o_full | w_do_rd);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_cluster_rr.sv
// Input port cluster: demultiplexes the leaf stream into per-port FIFOs
// bound to a (src_leaf, src_port) pair, flags drops on full FIFOs, and
// returns freespace credits through one round-robin arbitrated,
// backpressured credit packet output.
// Optional build macro INPUT_PORT_STATS_EN enables per-port accepted-word
// counters on o_port_stats; without it that port is tied to zero.
//
// state | meaning
// IDLE  | no credit on the output; grant the next pending port at/after ptr
// HOLD  | credit packet held on the output until i_credit_ready
module input_port_cluster_rr
  import input_port_cluster_pkg::*;
#(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int PAYLOAD_BITS          = 64,
  parameter int NUM_IN_PORTS          = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int PORT_BASE             = 2
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_reset,
  input  logic [PACKET_BITS-1:0]                               i_stream_in,
  input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0] i_in_control_reg,
  input  logic [NUM_IN_PORTS-1:0]                              i_port_enable,
  output logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]                 o_dout2user,
  output logic [NUM_IN_PORTS-1:0]                              o_vld2user,
  input  logic [NUM_IN_PORTS-1:0]                              i_ack_user2b_in,
  output logic [NUM_IN_PORTS-1:0]                              o_rd_en,
  output logic [NUM_IN_PORTS-1:0]                              o_freespace_update,
  output logic [PACKET_BITS-1:0]                               o_credit_packet,
  input  logic                                                 i_credit_ready,
  output logic [NUM_IN_PORTS-1:0]                              o_overflow,
  output logic [32*NUM_IN_PORTS-1:0]                           o_port_stats
);

  localparam int VALID_BIT = valid_bit(PACKET_BITS);
  localparam int LEAF_LSB  = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int PORT_LSB  = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int PL_MSB    = payload_msb(PAYLOAD_BITS);
  localparam int CTRL_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CONS_BITS = (FREESPACE_UPDATE_SIZE > 1) ? $clog2(FREESPACE_UPDATE_SIZE) : 1;
  localparam int PTR_BITS  = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;

  if (((1 << NUM_BRAM_ADDR_BITS) / FREESPACE_UPDATE_SIZE) > 15) begin : g_bad_credit_cfg
    $error("FIFO depth / FREESPACE_UPDATE_SIZE exceeds pending counter range");
  end

  logic                      r_s1_valid;
  logic [NUM_LEAF_BITS-1:0]  r_s1_leaf;
  logic [NUM_PORT_BITS-1:0]  r_s1_port;
  logic [PAYLOAD_BITS-1:0]   r_s1_payload;

  logic [NUM_LEAF_BITS-1:0]  w_src_leaf [NUM_IN_PORTS];
  logic [NUM_PORT_BITS-1:0]  w_src_port [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]   w_match;
  logic [NUM_IN_PORTS-1:0]   w_sel;
  logic [NUM_IN_PORTS-1:0]   w_accept;
  logic [NUM_IN_PORTS-1:0]   w_drop;
  logic [NUM_IN_PORTS-1:0]   w_full;
  logic [NUM_IN_PORTS-1:0]   w_empty;
  logic [NUM_IN_PORTS-1:0]   w_rd;
  logic [NUM_IN_PORTS-1:0]   w_wrap;
  logic [NUM_IN_PORTS-1:0]   w_dec;

  logic [NUM_IN_PORTS-1:0]   r_overflow;
  logic [NUM_IN_PORTS-1:0]   r_fsu;
  logic [CONS_BITS-1:0]      r_consumed [NUM_IN_PORTS];
  logic [PENDING_BITS-1:0]   r_pending  [NUM_IN_PORTS];

  arb_state_e                r_state;
  logic [PTR_BITS-1:0]       r_ptr;
  logic [PTR_BITS-1:0]       r_grant;
  logic [PACKET_BITS-1:0]    r_credit;
  logic [PTR_BITS-1:0]       w_pick;
  logic                      w_found;
  logic [PACKET_BITS-1:0]    w_credit_pkt;

  // Bits between the port field and the payload carry nothing on receive.
  if (PORT_LSB > PAYLOAD_BITS) begin : g_gap
    logic w_unused_gap;
    assign w_unused_gap = ^i_stream_in[PORT_LSB-1:PAYLOAD_BITS];
  end

  // Stage 1: register the incoming packet fields.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_leaf    <= '0;
      r_s1_port    <= '0;
      r_s1_payload <= '0;
    end else begin
      r_s1_valid   <= i_stream_in[VALID_BIT];
      r_s1_leaf    <= i_stream_in[LEAF_LSB +: NUM_LEAF_BITS];
      r_s1_port    <= i_stream_in[PORT_LSB +: NUM_PORT_BITS];
      r_s1_payload <= i_stream_in[PL_MSB:0];
    end
  end

  for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_port
    assign w_src_port[gi] = i_in_control_reg[gi*CTRL_BITS +: NUM_PORT_BITS];
    assign w_src_leaf[gi] = i_in_control_reg[gi*CTRL_BITS+NUM_PORT_BITS +: NUM_LEAF_BITS];
    assign w_match[gi]    = r_s1_valid & i_port_enable[gi] &
                            (r_s1_leaf == w_src_leaf[gi]) &
                            (r_s1_port == w_src_port[gi]);

    input_port_fifo #(
      .DATA_BITS (PAYLOAD_BITS),
      .ADDR_BITS (NUM_BRAM_ADDR_BITS)
    ) u_fifo (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_en   (w_accept[gi]),
      .i_wr_data (r_s1_payload),
      .i_rd_en   (w_rd[gi]),
      .o_head    (o_dout2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_empty   (w_empty[gi]),
      .o_full    (w_full[gi])
    );
  end

  // Lowest matching index wins; isolate the least significant set bit.
  assign w_sel    = w_match & ~(w_match - 1'b1);
  assign w_rd     = ~w_empty & i_ack_user2b_in;
  assign w_accept = w_sel & (~w_full | w_rd);
  assign w_drop   = w_sel & w_full & ~w_rd;

  assign o_vld2user         = ~w_empty;
  assign o_rd_en            = w_rd;
  assign o_overflow         = r_overflow;
  assign o_freespace_update = r_fsu;
  assign o_credit_packet    = r_credit;

  // Batch wrap detection and credit release on accepted credit packets.
  always_comb begin
    w_wrap = '0;
    w_dec  = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      w_wrap[i] = w_rd[i] & (r_consumed[i] == '1);
      w_dec[i]  = (r_state == HOLD) & i_credit_ready & (r_grant == PTR_BITS'(i));
    end
  end

  // Sticky overflow, consumed-word counters and pending credit counts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow <= '0;
      r_fsu      <= '0;
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        r_consumed[i] <= '0;
        r_pending[i]  <= '0;
      end
    end else begin
      r_overflow <= r_overflow | w_drop;
      r_fsu      <= w_wrap;
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (w_rd[i]) r_consumed[i] <= r_consumed[i] + 1'b1;
        r_pending[i] <= r_pending[i] + PENDING_BITS'(w_wrap[i]) - PENDING_BITS'(w_dec[i]);
      end
    end
  end

  // Round-robin search for the first pending port at or after r_ptr.
  always_comb begin
    int idx;
    w_pick  = r_ptr;
    w_found = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      idx = (int'(r_ptr) + k) % NUM_IN_PORTS;
      if (!w_found && (r_pending[idx] != '0)) begin
        w_found = 1'b1;
        w_pick  = PTR_BITS'(idx);
      end
    end
  end

  // Credit packet for the picked port: its source address plus its port number.
  always_comb begin
    w_credit_pkt            = '0;
    w_credit_pkt[VALID_BIT] = 1'b1;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (w_pick == PTR_BITS'(i)) begin
        w_credit_pkt[LEAF_LSB +: NUM_LEAF_BITS] = w_src_leaf[i];
        w_credit_pkt[PORT_LSB +: NUM_PORT_BITS] = w_src_port[i];
        w_credit_pkt[NUM_PORT_BITS-1:0]         = NUM_PORT_BITS'(PORT_BASE + i);
      end
    end
  end

  // Credit arbiter: grant in IDLE, hold until accepted, then advance the pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_credit <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant  <= w_pick;
            r_credit <= w_credit_pkt;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (i_credit_ready) begin
            r_ptr    <= (r_grant == PTR_BITS'(NUM_IN_PORTS-1)) ? '0 : r_grant + 1'b1;
            r_credit <= '0;
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef INPUT_PORT_STATS_EN
  logic [31:0] r_stats [NUM_IN_PORTS];

  // Accepted-word counters; dropped words are not counted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) r_stats[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (w_accept[i]) r_stats[i] <= r_stats[i] + 32'd1;
      end
    end
  end

  for (genvar gs = 0; gs < NUM_IN_PORTS; gs++) begin : g_stats
    assign o_port_stats[gs*32 +: 32] = r_stats[gs];
  end
`else
  assign o_port_stats = '0;
`endif

endmodule

// File: doc/input_port_cluster_rr.md
Name: input_port_cluster_rr

Overview:
- Parametrised successor of the leaf input-port cluster: demultiplexes the BFT leaf stream into NUM_IN_PORTS per-port buffered FIFOs, each bound to one (src_leaf, src_port) via in_control_reg.
- Adds per-port enable, drop/overflow detection, and credit return: freespace credits are round-robin-arbitrated onto one backpressured credit-packet output instead of per-port packet outputs.
- Sits between the leaf interface (bft2interface) and the user operator.

Parameters:
PACKET_BITS, 97, total packet width
NUM_LEAF_BITS, 6, leaf address field width
NUM_PORT_BITS, 4, port address field width
PAYLOAD_BITS, 64, payload width
NUM_IN_PORTS, 7, number of input ports
NUM_BRAM_ADDR_BITS, 7, log2 per-port FIFO depth (depth 128)
FREESPACE_UPDATE_SIZE, 64, words consumed per credit; power of two, <= FIFO depth
PORT_BASE, 2, port number of port 0; port i is PORT_BASE+i

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stream_in  in  PACKET_BITS  leaf-to-interface packet
in_control_reg  in  (NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS  per-port {src_leaf, src_port}; src_port in the low bits of each slice
port_enable  in  NUM_IN_PORTS  per-port accept enable
dout2user  out  PAYLOAD_BITS*NUM_IN_PORTS  FIFO head payloads
vld2user  out  NUM_IN_PORTS  FIFO non-empty
ack_user2b_in  in  NUM_IN_PORTS  user accept
rd_en  out  NUM_IN_PORTS  pop strobe
freespace_update  out  NUM_IN_PORTS  one-cycle pulse per completed credit batch
credit_packet  out  PACKET_BITS  credit packet; valid = MSB
credit_ready  in  1  downstream accepts credit_packet
overflow  out  NUM_IN_PORTS  sticky: matched word dropped on full FIFO
port_stats  out  32*NUM_IN_PORTS  per-port accepted-word counters (see Optional Feature)

Behaviour:
- Packet fields:
  - [PACKET_BITS-1] valid.
  - Next NUM_LEAF_BITS: leaf.
  - Next NUM_PORT_BITS: port.
  - Low PAYLOAD_BITS: payload.
  - Remaining bits are ignored on receive and zero on transmit.
- Reset: all outputs 0. FIFOs empty; counters, pending credits and arbiter pointer cleared. Reset mid-operation discards all buffered data and any unaccepted credit.
- Input stage:
  - stream_in is registered (stage 1).
  - Port i matches when valid=1, port_enable[i]=1, and leaf/port equal the port's in_control_reg slice.
  - Only the lowest matching index accepts.
- Write: on a match, the payload is written into FIFO i in the cycle after stage 1, so vld2user[i] rises 2 cycles after the packet appears on stream_in.
- Full FIFO on a match: the word is dropped, overflow[i] is set, and it stays set until reset.
- User handshake: vld2user[i] = !empty; dout2user slice = head word.
  - Pop when vld2user[i] & ack_user2b_in[i]; rd_en[i] equals that AND, combinational.
  - ack with vld low is ignored.
  - Simultaneous write and pop on a full FIFO is legal: the write is accepted and no overflow is flagged.
- Credit accounting: each pop increments consumed[i], which is log2(FREESPACE_UPDATE_SIZE) bits and wraps.
  - On wrap to 0: freespace_update[i] pulses for one cycle and pending[i] increments.
  - pending[i] is 4 bits; elaboration asserts depth/FREESPACE_UPDATE_SIZE <= 15.
- Credit arbiter, states IDLE/HOLD:
  - IDLE: if any pending[i] > 0, grant the first pending index at or after ptr. Register credit_packet with valid=1, leaf/port = port i's src slice, payload[NUM_PORT_BITS-1:0] = PORT_BASE+i, all other bits 0. Go to HOLD.
  - HOLD: credit_packet is held stable until credit_ready=1. On that cycle pending[g] decrements, ptr = g+1 mod NUM_IN_PORTS, valid drops next cycle, and the state returns to IDLE.
  - Maximum one credit per 2 cycles.
  - Same-cycle increment and decrement on one port leaves pending unchanged.

Optional Feature:
- Macro INPUT_PORT_STATS_EN.
- Defined: port_stats slice i counts words written into FIFO i (drops excluded). The counter is 32 bits, wraps, and clears on reset.
- Undefined: the port_stats port stays present and is tied to 0; no counter logic is generated.

Decomposition:
- Package input_port_cluster_pkg holds:
  - Field-offset functions (valid/leaf/port/payload positions from the widths).
  - The arbiter state enum {IDLE, HOLD}.
  - The pending-counter width constant (4).
- Sub-module input_port_fifo: synchronous FIFO of depth 2^NUM_BRAM_ADDR_BITS, first-word-fall-through head, full/empty, write-while-full-with-pop support. Instantiated once per port.

Test Plan:
- Config port0=(leaf 3, port 5), port1=(leaf 3, port 6); send payload 0xA1 to (3,5) at cycle 10 -> vld2user[0]=1 at cycle 12, dout=0xA1, vld2user[1]=0.
- port_enable[0]=0, send to (3,5) -> no write, no overflow; re-enable, send -> accepted.
- Fill port0 with 128 words without ack, send 129th -> overflow[0]=1, FIFO count stays 128; then ack one while a new word arrives -> accepted, count 128.
- Pop 64 words on port0 -> freespace_update[0] pulse on the 64th pop; credit_packet valid with leaf 3, port 5, payload 2; hold credit_ready=0 for 5 cycles -> packet stable; ready=1 -> accepted, valid drops next cycle.
- Ports 0, 2, 5 each complete a batch in the same cycle, ptr=3 -> credits emitted in order 5, 0, 2.
- Assert reset while port1 holds 10 words and a credit is in HOLD -> next cycle all vld2user=0, credit valid=0, overflow=0.
